// File: rtl/md_unit_param_if.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_param_if
// Brief    : Request/result bundle between the EX stage and the mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_param
// Brief    : Parametrised multiply/divide/accumulate unit owning HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  wire logic         clk,
    input  wire logic         reset,
    md_unit_param_if.slave    bus
);
    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_done;
    logic               w_done_next;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic               r_pend_dbz;

    // Operation decode
    logic w_signed;
    logic w_is_div;
    logic w_is_acc;
    logic w_is_sub;
    logic w_launch;
    logic w_commit;

    always_comb begin
        w_signed = ~bus.op[0];
        w_is_div = ~bus.op[2] & bus.op[1];
        w_is_acc = bus.op[2];
        w_is_sub = bus.op[2] & bus.op[1];
        w_launch = (r_state == S_IDLE) && bus.start;
        w_commit = (r_state == S_BUSY) && (r_cnt == c_CNT_W'(1));
    end

    // Multiply path: sign-extend to 2*WIDTH so one multiplier serves both signednesses
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_macc;

    always_comb begin
        w_a_ext = {{WIDTH{w_signed & bus.a[WIDTH-1]}}, bus.a};
        w_b_ext = {{WIDTH{w_signed & bus.b[WIDTH-1]}}, bus.b};
        w_prod  = w_a_ext * w_b_ext;
        w_acc   = {r_hi, r_lo};
        w_macc  = w_is_sub ? (w_acc - w_prod) : (w_acc + w_prod);
    end

    // Divide path: magnitude divide, then restore signs. MIN/-1 falls out naturally.
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        w_a_neg  = w_signed & bus.a[WIDTH-1];
        w_b_neg  = w_signed & bus.b[WIDTH-1];
        w_b_zero = (bus.b == '0);
        w_a_mag  = w_a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        w_b_mag  = w_b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        w_den    = w_b_zero ? WIDTH'(1) : w_b_mag;
        w_q_mag  = w_a_mag / w_den;
        w_r_mag  = w_a_mag % w_den;
        w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
        w_rem    = w_a_neg ? (~w_r_mag + WIDTH'(1)) : w_r_mag;
    end

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_res_dbz;

    always_comb begin
        w_res_hi  = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo  = w_prod[WIDTH-1:0];
        w_res_dbz = 1'b0;
        if (w_is_div) begin
            if (w_b_zero) begin
                // Divide by zero leaves HI/LO untouched at commit
                w_res_hi  = r_hi;
                w_res_lo  = r_lo;
                w_res_dbz = 1'b1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end else if (w_is_acc) begin
            w_res_hi = w_macc[2*WIDTH-1:WIDTH];
            w_res_lo = w_macc[WIDTH-1:0];
        end
    end

    // Control FSM
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_BUSY;
                    w_cnt_next   = w_is_div ? c_CNT_W'(DIV_LAT) : c_CNT_W'(MUL_LAT);
                end
            end
            S_BUSY: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        w_done_next = (w_state_next == S_BUSY) && (w_cnt_next == c_CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_pend_hi  <= '0;
            r_pend_lo  <= '0;
            r_pend_dbz <= 1'b0;
        end else if (w_launch) begin
            r_pend_hi  <= w_res_hi;
            r_pend_lo  <= w_res_lo;
            r_pend_dbz <= w_res_dbz;
        end else if (w_commit) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
        end else if (r_state == S_IDLE) begin
            if (bus.wr_hi) r_hi <= bus.wdata;
            if (bus.wr_lo) r_lo <= bus.wdata;
        end
    end

    assign bus.busy        = (r_state == S_BUSY);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_done & r_pend_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit_param
// Brief    : Directed vector bench for md_unit_param (WIDTH=32, 5/10 latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit_param;
    localparam int c_WIDTH = 32;
    localparam int c_MUL   = 5;
    localparam int c_DIV   = 10;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    md_unit_param_if #(.WIDTH(c_WIDTH)) bus ();

    md_unit_param #(
        .WIDTH   (c_WIDTH),
        .MUL_LAT (c_MUL),
        .DIV_LAT (c_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ihi;
        logic [31:0] ilo;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wdata = h;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wdata = l;
        @(negedge clk);
        bus.wr_lo = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    endtask

    // Launch in cycle 0, check busy/done/dbz each busy cycle and the commit
    task automatic run_op(input int idx, input vec_t v);
        int lat;
        lat = (v.op == 3'd2 || v.op == 3'd3) ? c_DIV : c_MUL;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            check($sformatf("v%0d busy c%0d", idx, c), 32'(bus.busy), 32'(1));
            check($sformatf("v%0d done c%0d", idx, c), 32'(bus.done), 32'(c == lat));
            check($sformatf("v%0d dbz c%0d", idx, c), 32'(bus.div_by_zero), 32'((c == lat) && v.edbz));
            @(negedge clk);
        end
        check($sformatf("v%0d busy end", idx), 32'(bus.busy), 32'(0));
        check($sformatf("v%0d done end", idx), 32'(bus.done), 32'(0));
        check($sformatf("v%0d hi", idx), bus.hi, v.ehi);
        check($sformatf("v%0d lo", idx), bus.lo, v.elo);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //          op    a             b             ihi           ilo           ehi           elo           dbz
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[3]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000, 1'b0};
        vecs[4]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h0,        32'h0,        32'h00000001, 32'h00000003, 1'b0};
        vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0,        32'h0,        32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[9]  = '{3'd2, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 1'b1};
        vecs[10] = '{3'd3, 32'h00000009, 32'h00000000, 32'h000000AA, 32'h000000BB, 32'h000000AA, 32'h000000BB, 1'b1};
        vecs[11] = '{3'd5, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[12] = '{3'd6, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{3'd4, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[14] = '{3'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[15] = '{3'd5, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000005, 32'h00000002, 32'h00000003, 1'b0};

        reset = 1'b1;
        idle_inputs();
        bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'(0));
        check("reset done", 32'(bus.done), 32'(0));
        check("reset dbz", 32'(bus.div_by_zero), 32'(0));
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            set_hilo(vecs[i].ihi, vecs[i].ilo);
            run_op(i, vecs[i]);
        end

        // Simultaneous mthi/mtlo while idle
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h00001234;
        @(negedge clk);
        idle_inputs();
        check("both wr hi", bus.hi, 32'h00001234);
        check("both wr lo", bus.lo, 32'h00001234);

        // start and mtlo during busy are ignored
        set_hilo(32'h0, 32'h0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
        bus.wr_lo = 1'b1; bus.wdata = 32'h00000055;
        @(negedge clk);
        idle_inputs();
        check("ign busy c3", 32'(bus.busy), 32'(1));
        check("ign lo c3", bus.lo, 32'h0);
        repeat (2) @(negedge clk);
        check("ign done c5", 32'(bus.done), 32'(1));
        @(negedge clk);
        check("ign busy c6", 32'(bus.busy), 32'(0));
        check("ign hi c6", bus.hi, 32'h0);
        check("ign lo c6", bus.lo, 32'd15);
        @(negedge clk);
        check("ign busy c7", 32'(bus.busy), 32'(0));

        // start wins over a same-cycle mtlo
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd2; bus.b = 32'd3;
        bus.wr_lo = 1'b1; bus.wdata = 32'h00000099;
        @(negedge clk);
        idle_inputs();
        check("same lo c1", bus.lo, 32'd15);
        repeat (5) @(negedge clk);
        check("same busy c6", 32'(bus.busy), 32'(0));
        check("same lo c6", bus.lo, 32'd6);

        // Reset in cycle 3 of a divide discards it
        set_hilo(32'h7, 32'h8);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst busy c4", 32'(bus.busy), 32'(0));
        check("rst done c4", 32'(bus.done), 32'(0));
        check("rst hi c4", bus.hi, 32'h0);
        check("rst lo c4", bus.lo, 32'h0);
        begin
            int activity;
            activity = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (bus.busy || bus.done) activity++;
            end
            check("rst no later activity", 32'(activity), 32'(0));
        end
        check("rst hi late", bus.hi, 32'h0);
        check("rst lo late", bus.lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
